// File: rtl/bomberman_pkg.sv
// Shared types and helpers for the bomb scheduling slice: playfield origin,
// tile size, per-slot lifecycle states and the pixel-to-tile snap.
package bomberman_pkg;

    localparam logic [9:0] MIN_X  = 10'd143;
    localparam logic [9:0] MIN_Y  = 10'd34;
    localparam logic [9:0] T_SIZE = 10'd16;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        FUSE  = 2'd1,
        PEND  = 2'd2,
        BLAST = 2'd3
    } slot_state_t;

    // Rounds a pixel coordinate down to the top-left corner of its tile.
    function automatic logic [9:0] snap(input logic [9:0] p, input logic [9:0] min_p);
        return p - ((p - min_p) & (T_SIZE - 10'd1));
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: lifecycle FSM, tile coordinates, shared fuse/blast counter
// and the proximity test that lets a neighbouring detonation set it off.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_TICKS = 2,
    parameter int BLAST_RANGE = 2
) (
    input  logic       sys_clk,
    input  logic       Reset,
    input  logic       tick_en,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic       grant,
    input  logic       chain_en,
    input  logic [9:0] chain_x,
    input  logic [9:0] chain_y,
    output logic       busy,
    output logic       pend,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int CNT_W = $clog2((FUSE_TICKS > BLAST_TICKS ? FUSE_TICKS : BLAST_TICKS) + 1);
    localparam logic [9:0] RANGE_PX = 10'(BLAST_RANGE * 16);

    slot_state_t      state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_range;

    assign dx = (x_q >= chain_x) ? (x_q - chain_x) : (chain_x - x_q);
    assign dy = (y_q >= chain_y) ? (y_q - chain_y) : (chain_y - y_q);
    assign in_range = ((y_q == chain_y) && (dx <= RANGE_PX)) ||
                      ((x_q == chain_x) && (dy <= RANGE_PX));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            FREE: begin
                if (load) begin
                    state_d = FUSE;
                    x_d     = load_x;
                    y_d     = load_y;
                    cnt_d   = CNT_W'(FUSE_TICKS);
                end
            end
            FUSE: begin
                // A chain trigger and a natural expiry in the same cycle both just mean PEND.
                if (tick_en) begin
                    if (cnt_q == CNT_W'(1)) state_d = PEND;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                if (chain_en && in_range) state_d = PEND;
            end
            PEND: begin
                if (grant) begin
                    state_d = BLAST;
                    cnt_d   = CNT_W'(BLAST_TICKS);
                end
            end
            BLAST: begin
                if (tick_en) begin
                    if (cnt_q == CNT_W'(1)) state_d = FREE;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FREE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != FREE);
    assign pend = (state_q == PEND);
    assign x    = x_q;
    assign y    = y_q;

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb scheduler: allocates slots on place requests, round-robin arbitrates
// pending detonations onto the single shared explosion broadcast.
module bomb_scheduler
    import bomberman_pkg::*;
#(
    parameter int N_BOMBS     = 4,
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_TICKS = 2,
    parameter int BLAST_RANGE = 2
) (
    input  logic                  sys_clk,
    input  logic                  Reset,
    input  logic                  tick_en,
    input  logic                  place,
    input  logic [9:0]            b_x,
    input  logic [9:0]            b_y,
    output logic                  place_ok,
    output logic                  place_reject,
    output logic [N_BOMBS-1:0]    slot_busy,
    output logic [10*N_BOMBS-1:0] slot_x,
    output logic [10*N_BOMBS-1:0] slot_y,
    output logic [9:0]            exploding_bomb_x,
    output logic [9:0]            exploding_bomb_y,
    output logic                  explosion_write_enable
);

    localparam int PTR_W = $clog2(N_BOMBS);

    logic [9:0]         snap_x, snap_y;
    logic [N_BOMBS-1:0] load, grant, pend;
    logic               grant_found;
    logic [9:0]         grant_x, grant_y;

    logic             place_ok_q, place_ok_d;
    logic             place_reject_q, place_reject_d;
    logic             ewe_q, ewe_d;
    logic [9:0]       ex_q, ex_d;
    logic [9:0]       ey_q, ey_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign snap_x = snap(b_x, MIN_X);
    assign snap_y = snap(b_y, MIN_Y);

    // Allocation looks only at registered slot state, so a slot freed this cycle is offered next cycle.
    always_comb begin
        logic dup;
        logic free_found;
        int   alloc_idx;
        dup        = 1'b0;
        free_found = 1'b0;
        alloc_idx  = 0;
        load       = '0;
        for (int i = 0; i < N_BOMBS; i++) begin
            if (slot_busy[i] && slot_x[i*10 +: 10] == snap_x && slot_y[i*10 +: 10] == snap_y)
                dup = 1'b1;
            if (!slot_busy[i] && !free_found) begin
                free_found = 1'b1;
                alloc_idx  = i;
            end
        end
        if (place && free_found && !dup) load[alloc_idx] = 1'b1;
        place_ok_d     = place && free_found && !dup;
        place_reject_d = place && !(free_found && !dup);
    end

    // The granted coordinates are fed straight back to the slots so chained bombs go PEND in the pulse cycle.
    always_comb begin
        int idx;
        int grant_idx;
        idx         = 0;
        grant_idx   = 0;
        grant_found = 1'b0;
        grant       = '0;
        for (int k = 0; k < N_BOMBS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_BOMBS) idx = idx - N_BOMBS;
            if (!grant_found && pend[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_found) grant[grant_idx] = 1'b1;
        grant_x = slot_x[grant_idx*10 +: 10];
        grant_y = slot_y[grant_idx*10 +: 10];
        ewe_d   = grant_found;
        ex_d    = grant_found ? grant_x : ex_q;
        ey_d    = grant_found ? grant_y : ey_q;
        ptr_d   = grant_found ? PTR_W'((grant_idx + 1) % N_BOMBS) : ptr_q;
    end

    for (genvar i = 0; i < N_BOMBS; i++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS (FUSE_TICKS),
            .BLAST_TICKS(BLAST_TICKS),
            .BLAST_RANGE(BLAST_RANGE)
        ) u_slot (
            .sys_clk (sys_clk),
            .Reset   (Reset),
            .tick_en (tick_en),
            .load    (load[i]),
            .load_x  (snap_x),
            .load_y  (snap_y),
            .grant   (grant[i]),
            .chain_en(grant_found),
            .chain_x (grant_x),
            .chain_y (grant_y),
            .busy    (slot_busy[i]),
            .pend    (pend[i]),
            .x       (slot_x[i*10 +: 10]),
            .y       (slot_y[i*10 +: 10])
        );
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            place_ok_q     <= 1'b0;
            place_reject_q <= 1'b0;
            ewe_q          <= 1'b0;
            ex_q           <= '0;
            ey_q           <= '0;
            ptr_q          <= '0;
        end else begin
            place_ok_q     <= place_ok_d;
            place_reject_q <= place_reject_d;
            ewe_q          <= ewe_d;
            ex_q           <= ex_d;
            ey_q           <= ey_d;
            ptr_q          <= ptr_d;
        end
    end

    assign place_ok               = place_ok_q;
    assign place_reject           = place_reject_q;
    assign explosion_write_enable = ewe_q;
    assign exploding_bomb_x       = ex_q;
    assign exploding_bomb_y       = ey_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: placement, fuse/blast timing, chain
// reactions, round-robin order and asynchronous reset.
module tb_bomb_scheduler;

    logic        sys_clk = 1'b0;
    logic        Reset   = 1'b1;
    logic        tick_en = 1'b0;
    logic        place   = 1'b0;
    logic [9:0]  b_x     = '0;
    logic [9:0]  b_y     = '0;
    logic        place_ok, place_reject, explosion_write_enable;
    logic [3:0]  slot_busy;
    logic [39:0] slot_x, slot_y;
    logic [9:0]  exploding_bomb_x, exploding_bomb_y;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    bomb_scheduler #(
        .N_BOMBS(4), .FUSE_TICKS(3), .BLAST_TICKS(2), .BLAST_RANGE(2)
    ) dut (
        .sys_clk               (sys_clk),
        .Reset                 (Reset),
        .tick_en               (tick_en),
        .place                 (place),
        .b_x                   (b_x),
        .b_y                   (b_y),
        .place_ok              (place_ok),
        .place_reject          (place_reject),
        .slot_busy             (slot_busy),
        .slot_x                (slot_x),
        .slot_y                (slot_y),
        .exploding_bomb_x      (exploding_bomb_x),
        .exploding_bomb_y      (exploding_bomb_y),
        .explosion_write_enable(explosion_write_enable)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        tick_en = 1'b0;
        place   = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y);
        b_x   = x;
        b_y   = y;
        place = 1'b1;
        step();
        place = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_en = 1'b1;
        repeat (n) step();
        tick_en = 1'b0;
    endtask

    function automatic logic [9:0] sx(input int i);
        return slot_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return slot_y[i*10 +: 10];
    endfunction

    initial begin
        $display("[TB] start");

        // Basic placement, fuse, detonation pulse and blast hold
        do_reset();
        check_output("rst_busy", slot_busy, 0);
        check_output("rst_ok", place_ok, 0);
        check_output("rst_rej", place_reject, 0);
        check_output("rst_ewe", explosion_write_enable, 0);
        check_output("rst_ex", exploding_bomb_x, 0);
        check_output("rst_ey", exploding_bomb_y, 0);
        check_output("rst_sx_zero", {63'd0, |slot_x}, 0);
        apply_stimulus(10'd200, 10'd100);
        check_output("t1_ok", place_ok, 1);
        check_output("t1_rej", place_reject, 0);
        check_output("t1_busy", slot_busy, 4'b0001);
        check_output("t1_sx0", sx(0), 191);
        check_output("t1_sy0", sy(0), 98);
        ticks(3);
        check_output("t1_pend_ewe", explosion_write_enable, 0);
        step();
        check_output("t1_ewe", explosion_write_enable, 1);
        check_output("t1_ex", exploding_bomb_x, 191);
        check_output("t1_ey", exploding_bomb_y, 98);
        step();
        check_output("t1_ewe_off", explosion_write_enable, 0);
        check_output("t1_ex_hold", exploding_bomb_x, 191);
        ticks(1);
        check_output("t1_blast_busy", slot_busy, 4'b0001);
        ticks(1);
        check_output("t1_freed", slot_busy, 4'b0000);

        // Duplicate tile and full-table rejection
        do_reset();
        apply_stimulus(10'd200, 10'd100);
        check_output("t2_ok0", place_ok, 1);
        apply_stimulus(10'd205, 10'd110);
        check_output("t2_dup_rej", place_reject, 1);
        check_output("t2_dup_ok", place_ok, 0);
        check_output("t2_dup_busy", slot_busy, 4'b0001);
        apply_stimulus(10'd207, 10'd98);
        check_output("t2_ok1", place_ok, 1);
        apply_stimulus(10'd223, 10'd98);
        check_output("t2_ok2", place_ok, 1);
        apply_stimulus(10'd239, 10'd98);
        check_output("t2_ok3", place_ok, 1);
        check_output("t2_sx3", sx(3), 239);
        apply_stimulus(10'd255, 10'd98);
        check_output("t2_full_rej", place_reject, 1);
        check_output("t2_full_ok", place_ok, 0);
        check_output("t2_full_busy", slot_busy, 4'b1111);

        // Chain reaction within range
        do_reset();
        apply_stimulus(10'd191, 10'd98);
        ticks(1);
        apply_stimulus(10'd223, 10'd98);
        check_output("t3_ok_b", place_ok, 1);
        ticks(2);
        check_output("t3_pend_ewe", explosion_write_enable, 0);
        check_output("t3_pend_busy", slot_busy, 4'b0011);
        step();
        check_output("t3_ewe_a", explosion_write_enable, 1);
        check_output("t3_ex_a", exploding_bomb_x, 191);
        step();
        check_output("t3_ewe_b", explosion_write_enable, 1);
        check_output("t3_ex_b", exploding_bomb_x, 223);
        check_output("t3_ey_b", exploding_bomb_y, 98);
        step();
        check_output("t3_ewe_off", explosion_write_enable, 0);

        // Out of range: no chain
        do_reset();
        apply_stimulus(10'd191, 10'd98);
        ticks(1);
        apply_stimulus(10'd255, 10'd98);
        ticks(2);
        step();
        check_output("t4_ewe_a", explosion_write_enable, 1);
        check_output("t4_ex_a", exploding_bomb_x, 191);
        step();
        check_output("t4_no_chain1", explosion_write_enable, 0);
        step();
        check_output("t4_no_chain2", explosion_write_enable, 0);
        check_output("t4_busy", slot_busy, 4'b0011);
        ticks(1);
        check_output("t4_pend_ewe", explosion_write_enable, 0);
        step();
        check_output("t4_ewe_b", explosion_write_enable, 1);
        check_output("t4_ex_b", exploding_bomb_x, 255);
        check_output("t4_ey_b", exploding_bomb_y, 98);

        // Round-robin from pointer 2
        do_reset();
        apply_stimulus(10'd191, 10'd98);
        apply_stimulus(10'd239, 10'd146);
        tick_en = 1'b1;
        step();
        step();
        step();
        check_output("t5_pend_ewe", explosion_write_enable, 0);
        step();
        check_output("t5_g0_x", exploding_bomb_x, 191);
        step();
        check_output("t5_g1_x", exploding_bomb_x, 239);
        check_output("t5_g1_y", exploding_bomb_y, 146);
        step();
        tick_en = 1'b0;
        check_output("t5_slot0_free", slot_busy, 4'b0010);
        apply_stimulus(10'd191, 10'd98);
        check_output("t5_ok_s0", place_ok, 1);
        apply_stimulus(10'd287, 10'd194);
        apply_stimulus(10'd335, 10'd242);
        check_output("t5_busy_all", slot_busy, 4'b1111);
        check_output("t5_sx2", sx(2), 287);
        ticks(1);
        check_output("t5_busy_1101", slot_busy, 4'b1101);
        ticks(2);
        check_output("t5_pend3_ewe", explosion_write_enable, 0);
        step();
        check_output("t5_rr2_ewe", explosion_write_enable, 1);
        check_output("t5_rr2_x", exploding_bomb_x, 287);
        check_output("t5_rr2_y", exploding_bomb_y, 194);
        step();
        check_output("t5_rr3_ewe", explosion_write_enable, 1);
        check_output("t5_rr3_x", exploding_bomb_x, 335);
        step();
        check_output("t5_rr0_ewe", explosion_write_enable, 1);
        check_output("t5_rr0_x", exploding_bomb_x, 191);
        step();
        check_output("t5_rr_done", explosion_write_enable, 0);
        ticks(2);
        check_output("t5_all_free", slot_busy, 4'b0000);
        apply_stimulus(10'd191, 10'd98);
        apply_stimulus(10'd239, 10'd146);
        ticks(3);
        step();
        check_output("t5_ptr1_x", exploding_bomb_x, 239);
        step();
        check_output("t5_ptr1_next_x", exploding_bomb_x, 191);

        // Asynchronous reset mid-fuse and mid-blast
        do_reset();
        apply_stimulus(10'd191, 10'd98);
        ticks(3);
        step();
        check_output("t6_ewe", explosion_write_enable, 1);
        apply_stimulus(10'd239, 10'd146);
        check_output("t6_ok", place_ok, 1);
        check_output("t6_busy", slot_busy, 4'b0011);
        check_output("t6_ex", exploding_bomb_x, 191);
        #2;
        Reset = 1'b1;
        #1;
        check_output("t6_async_ok", place_ok, 0);
        check_output("t6_async_busy", slot_busy, 0);
        check_output("t6_async_ex", exploding_bomb_x, 0);
        check_output("t6_async_ey", exploding_bomb_y, 0);
        check_output("t6_async_sx", {63'd0, |slot_x}, 0);
        check_output("t6_async_sy", {63'd0, |slot_y}, 0);
        tick_en = 1'b1;
        step();
        step();
        tick_en = 1'b0;
        Reset   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("t6_no_pulse", explosion_write_enable, 0);
        end
        apply_stimulus(10'd200, 10'd100);
        check_output("t6_ok_after", place_ok, 1);
        check_output("t6_busy_after", slot_busy, 4'b0001);
        check_output("t6_sx0_after", sx(0), 191);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
